// File: rtl/control_corrimiento.sv
// control_corrimiento: sequential shift unit, one bit position per clock,
// valid/ready on both sides. Define CORRIMIENTO_FLAGS_EN to add Z/C flags.
module control_corrimiento #(
    parameter int N  = 4,
    parameter int DW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  F,
    input  logic [2:0]    H,
    input  logic [DW-1:0] D,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  S,
`ifdef CORRIMIENTO_FLAGS_EN
    output logic          Z,
    output logic          C,
`endif
    output logic          busy
);

    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_SHL  = 3'b001;
    localparam logic [2:0] OP_SHR  = 3'b010;
    localparam logic [2:0] OP_ZERO = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;
    localparam logic [2:0] OP_ROR  = 3'b101;
    localparam logic [2:0] OP_ASL  = 3'b110;
    localparam logic [2:0] OP_ASR  = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [N-1:0]    acc;
    logic [N-1:0]    step_acc;
    logic [2:0]      op;
    logic [DW-1:0]   cnt;
    logic            accept;
    logic            trivial;
    logic            last_step;

    assign accept    = in_valid && (state == IDLE);
    assign trivial   = (H == OP_PASS) || (H == OP_ZERO) || (D == '0);
    assign last_step = (cnt == DW'(1));

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_next = trivial ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the state
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            DONE: begin
                out_valid = 1'b1;
            end
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // One single-bit step of the latched operation
    always_comb begin
        step_acc = acc;
        case (op)
            OP_SHL:  step_acc = {acc[N-2:0], 1'b0};
            OP_SHR:  step_acc = {1'b0, acc[N-1:1]};
            OP_ROL:  step_acc = {acc[N-2:0], acc[N-1]};
            OP_ROR:  step_acc = {acc[0], acc[N-1:1]};
            OP_ASL:  step_acc = {acc[N-1], acc[N-3:0], 1'b0};
            OP_ASR:  step_acc = {acc[N-1], acc[N-1:1]};
            default: step_acc = acc;
        endcase
    end

    // Accumulator, latched op and remaining-step counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
            op  <= OP_PASS;
            cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc <= (H == OP_ZERO) ? '0 : F;
                        op  <= H;
                        cnt <= D;
                    end
                end
                SHIFT: begin
                    acc <= step_acc;
                    cnt <= cnt - DW'(1);
                end
                default: begin
                    acc <= acc;
                end
            endcase
        end
    end

    assign S = acc;

`ifdef CORRIMIENTO_FLAGS_EN
    logic step_c;
    logic c_q;

    // Bit that leaves the word on the current step
    always_comb begin
        step_c = 1'b0;
        case (op)
            OP_SHL:  step_c = acc[N-1];
            OP_SHR:  step_c = acc[0];
            OP_ROL:  step_c = acc[N-1];
            OP_ROR:  step_c = acc[0];
            OP_ASL:  step_c = acc[N-2];
            OP_ASR:  step_c = acc[0];
            default: step_c = 1'b0;
        endcase
    end

    // Carry flag: cleared on accept, follows each step
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c_q <= 1'b0;
        end else if (accept) begin
            c_q <= 1'b0;
        end else if (state == SHIFT) begin
            c_q <= step_c;
        end
    end

    assign C = c_q;
    assign Z = (acc == '0);
`endif

endmodule
